// File: rtl/z80_io_resp.sv
// Z80-side I/O responder: command mailbox from the 68k, reply latch, NMI
// request generation and ROM window bank registers.
`timescale 1ns/1ps
module z80_io_resp (
  input  logic        CLK_4M,
  input  logic        nRESET,
  input  logic [15:0] SDA,
  input  logic [7:0]  SDD_IN,
  output logic [7:0]  SDD_OUT,
  output logic        SDD_OE,
  input  logic        nIORQ,
  input  logic        nMREQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic [7:0]  CMD_DATA,
  input  logic        CMD_WR,
  output logic [7:0]  REPLY,
  output logic        CMD_PENDING,
  output logic        nNMI,
  output logic [7:0]  BANK0,
  output logic [7:0]  BANK1,
  output logic [7:0]  BANK2,
  output logic [7:0]  BANK3
);

  localparam logic [4:0] PORT_CMD     = 5'h00;
  localparam logic [4:0] PORT_NMI_EN  = 5'h08;
  localparam logic [4:0] PORT_REPLY   = 5'h0C;
  localparam logic [4:0] PORT_NMI_DIS = 5'h18;

  logic [4:0] port;
  logic       bank_port;
  logic       io_rd, io_wr, int_ack;
  logic       rd_q, wr_q, armed;
  logic       rd_fire, wr_fire, nmi_dis_now;
  logic [7:0] cmd_q;
  logic [7:0] reply_q;
  logic       pending_q, nmi_en_q, nmi_n_q;
  logic [7:0] bank_q [4];
  logic       unused_sda;

  assign port       = SDA[4:0];
  assign bank_port  = (port[4:2] == 3'b010);
  assign unused_sda = ^SDA[7:5];

  assign io_rd   = !nIORQ && !nRD && nMREQ;
  assign io_wr   = !nIORQ && !nWR && nMREQ;
  assign int_ack = !nIORQ && nRD && nWR && nMREQ;

  // armed stays low for the first edge after reset so an access already in
  // progress at release only establishes history instead of firing.
  assign rd_fire     = io_rd && !rd_q && armed;
  assign wr_fire     = io_wr && !wr_q && armed;
  assign nmi_dis_now = wr_fire && (port == PORT_NMI_DIS);

  always_comb begin
    SDD_OUT = '0;
    SDD_OE  = 1'b0;
    if (nWR) begin
      if (io_rd && port == PORT_CMD) begin
        SDD_OUT = cmd_q;
        SDD_OE  = 1'b1;
      end else if ((io_rd && bank_port) || int_ack) begin
        SDD_OUT = '1;
        SDD_OE  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_4M or negedge nRESET) begin
    if (!nRESET) begin
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      armed     <= 1'b0;
      cmd_q     <= '0;
      reply_q   <= '0;
      pending_q <= 1'b0;
      nmi_en_q  <= 1'b0;
      nmi_n_q   <= 1'b1;
      bank_q[0] <= 8'h1E;
      bank_q[1] <= 8'h0E;
      bank_q[2] <= 8'h06;
      bank_q[3] <= 8'h02;
    end else begin
      armed <= 1'b1;
      rd_q  <= io_rd;
      wr_q  <= io_wr;

      if (rd_fire && port == PORT_CMD) begin
        pending_q <= 1'b0;
        nmi_n_q   <= 1'b1;
      end
      if (rd_fire && bank_port)
        bank_q[port[1:0]] <= SDA[15:8];

      if (wr_fire) begin
        case (port)
          PORT_NMI_EN:  nmi_en_q <= 1'b1;
          PORT_NMI_DIS: begin
            nmi_en_q <= 1'b0;
            nmi_n_q  <= 1'b1;
          end
          PORT_REPLY:   reply_q <= SDD_IN;
          PORT_CMD:     nmi_n_q <= 1'b1;
          default:      ;
        endcase
      end

      // A new command overrides a simultaneous read acknowledge, but an NMI
      // disable on the same edge keeps the request line released.
      if (CMD_WR) begin
        cmd_q     <= CMD_DATA;
        pending_q <= 1'b1;
        if (nmi_en_q && !nmi_dis_now)
          nmi_n_q <= 1'b0;
      end
    end
  end

  assign REPLY       = reply_q;
  assign CMD_PENDING = pending_q;
  assign nNMI        = nmi_n_q;
  assign BANK0       = bank_q[0];
  assign BANK1       = bank_q[1];
  assign BANK2       = bank_q[2];
  assign BANK3       = bank_q[3];

endmodule

// File: tb/tb_z80_io_resp.sv
// Scoreboard bench for z80_io_resp: directed bus cycles push expected values,
// a negedge monitor pops and compares them on their due cycle.
`timescale 1ns/1ps
module tb_z80_io_resp;

  logic        CLK_4M = 1'b0;
  logic        nRESET;
  logic [15:0] SDA;
  logic [7:0]  SDD_IN;
  logic [7:0]  SDD_OUT;
  logic        SDD_OE;
  logic        nIORQ, nMREQ, nRD, nWR;
  logic [7:0]  CMD_DATA;
  logic        CMD_WR;
  logic [7:0]  REPLY;
  logic        CMD_PENDING;
  logic        nNMI;
  logic [7:0]  BANK0, BANK1, BANK2, BANK3;

  z80_io_resp dut (
    .CLK_4M(CLK_4M), .nRESET(nRESET), .SDA(SDA), .SDD_IN(SDD_IN),
    .SDD_OUT(SDD_OUT), .SDD_OE(SDD_OE), .nIORQ(nIORQ), .nMREQ(nMREQ),
    .nRD(nRD), .nWR(nWR), .CMD_DATA(CMD_DATA), .CMD_WR(CMD_WR),
    .REPLY(REPLY), .CMD_PENDING(CMD_PENDING), .nNMI(nNMI),
    .BANK0(BANK0), .BANK1(BANK1), .BANK2(BANK2), .BANK3(BANK3)
  );

  always #5 CLK_4M = ~CLK_4M;

  localparam int S_OUT = 0, S_OE = 1, S_REPLY = 2, S_PEND = 3, S_NMI = 4,
                 S_B0 = 5, S_B1 = 6, S_B2 = 7, S_B3 = 8;
  localparam int K_NONE = 0, K_RD = 1, K_WR = 2, K_ACK = 3, K_MEM = 4;

  typedef struct {
    int         due;
    int         id;
    logic [7:0] exp;
    string      name;
  } chk_t;

  chk_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge CLK_4M) cyc <= cyc + 1;

  function automatic logic [7:0] probe(int id);
    case (id)
      S_OUT:   return SDD_OUT;
      S_OE:    return {7'b0, SDD_OE};
      S_REPLY: return REPLY;
      S_PEND:  return {7'b0, CMD_PENDING};
      S_NMI:   return {7'b0, nNMI};
      S_B0:    return BANK0;
      S_B1:    return BANK1;
      S_B2:    return BANK2;
      default: return BANK3;
    endcase
  endfunction

  chk_t mc;
  always @(negedge CLK_4M) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mc = sb.pop_front();
      n_chk++;
      if (mc.due != cyc || probe(mc.id) !== mc.exp) begin
        n_fail++;
        $display("FAIL %s: got %02h expected %02h (due cycle %0d, now %0d)",
                 mc.name, probe(mc.id), mc.exp, mc.due, cyc);
      end
    end
  end

  task automatic expect_v(int id, logic [7:0] v, string nm);
    chk_t c;
    c.due  = cyc;
    c.id   = id;
    c.exp  = v;
    c.name = nm;
    sb.push_back(c);
  endtask

  task automatic drive(int kind, logic [15:0] a, logic [7:0] d, logic cw, logic [7:0] cd);
    SDA = a; SDD_IN = d; CMD_WR = cw; CMD_DATA = cd;
    nIORQ = 1'b1; nMREQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
    case (kind)
      K_RD:  begin nIORQ = 1'b0; nRD = 1'b0; end
      K_WR:  begin nIORQ = 1'b0; nWR = 1'b0; end
      K_ACK: nIORQ = 1'b0;
      K_MEM: begin nIORQ = 1'b0; nMREQ = 1'b0; nRD = 1'b0; end
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge CLK_4M);
    #1;
    drive(K_NONE, 16'h0000, 8'h00, 1'b0, 8'h00);
  endtask

  // One idle clock precedes every access so each strobe is a fresh edge.
  task automatic acc(int kind, logic [15:0] a, logic [7:0] d, logic cw, logic [7:0] cd);
    step();
    drive(kind, a, d, cw, cd);
  endtask

  initial begin
    drive(K_NONE, 16'h0000, 8'h00, 1'b0, 8'h00);
    nRESET = 1'b0;
    repeat (2) @(posedge CLK_4M);
    #1;
    // reset state, with an IORD 0x00 showing SDD_OE follows strobes in reset
    drive(K_RD, 16'h0000, 8'h00, 1'b0, 8'h00);
    expect_v(S_OUT, 8'h00, "rst_out");
    expect_v(S_OE, 8'h01, "rst_oe");
    expect_v(S_PEND, 8'h00, "rst_pend");
    expect_v(S_NMI, 8'h01, "rst_nmi");
    expect_v(S_REPLY, 8'h00, "rst_reply");
    expect_v(S_B0, 8'h1E, "rst_b0");
    expect_v(S_B1, 8'h0E, "rst_b1");
    expect_v(S_B2, 8'h06, "rst_b2");
    expect_v(S_B3, 8'h02, "rst_b3");
    step();
    nRESET = 1'b1;
    step();

    // NMI-enabled command delivery and read acknowledge
    acc(K_WR, 16'h0008, 8'h00, 1'b0, 8'h00); step();
    acc(K_NONE, 16'h0000, 8'h00, 1'b1, 8'h5A); step();
    expect_v(S_PEND, 8'h01, "cmd5a_pend");
    expect_v(S_NMI, 8'h00, "cmd5a_nmi");
    acc(K_RD, 16'h0000, 8'h00, 1'b0, 8'h00);
    expect_v(S_OUT, 8'h5A, "rd5a_out");
    expect_v(S_OE, 8'h01, "rd5a_oe");
    #1;
    n_chk++;
    if (SDD_OUT !== 8'h5A || SDD_OE !== 1'b1) begin
      n_fail++;
      $display("FAIL direct_rd5a: got %02h oe %b", SDD_OUT, SDD_OE);
    end
    step();
    expect_v(S_PEND, 8'h00, "rd5a_pend");
    expect_v(S_NMI, 8'h01, "rd5a_nmi");

    // NMI disabled
    acc(K_WR, 16'h0018, 8'h00, 1'b0, 8'h00); step();
    acc(K_NONE, 16'h0000, 8'h00, 1'b1, 8'h33); step();
    expect_v(S_PEND, 8'h01, "cmd33_pend");
    expect_v(S_NMI, 8'h01, "cmd33_nmi");
    acc(K_RD, 16'h0000, 8'h00, 1'b0, 8'h00);
    expect_v(S_OUT, 8'h33, "rd33_out");
    step();

    // bank registers
    acc(K_RD, 16'h2109, 8'h00, 1'b0, 8'h00);
    expect_v(S_OUT, 8'hFF, "bank_rd_out");
    expect_v(S_OE, 8'h01, "bank_rd_oe");
    step();
    expect_v(S_B1, 8'h21, "bank1_21");
    n_chk++;
    if (BANK1 !== 8'h21) begin
      n_fail++;
      $display("FAIL direct_bank1: got %02h expected 21", BANK1);
    end
    acc(K_RD, 16'h7F0B, 8'h00, 1'b0, 8'h00); step();
    expect_v(S_B3, 8'h7F, "bank3_7f");
    expect_v(S_B0, 8'h1E, "bank0_keep");
    expect_v(S_B1, 8'h21, "bank1_keep");
    expect_v(S_B2, 8'h06, "bank2_keep");

    // reply latch
    acc(K_WR, 16'h000C, 8'hA5, 1'b0, 8'h00);
    expect_v(S_OE, 8'h00, "wr0c_oe");
    step();
    expect_v(S_REPLY, 8'hA5, "reply_a5");
    acc(K_WR, 16'h000D, 8'h3C, 1'b0, 8'h00);
    expect_v(S_OE, 8'h00, "wr0d_oe");
    step();
    expect_v(S_REPLY, 8'hA5, "reply_keep");

    // CMD_WR coincident with command read (nmi_en=0)
    acc(K_NONE, 16'h0000, 8'h00, 1'b1, 8'h11); step();
    acc(K_RD, 16'h0000, 8'h00, 1'b1, 8'h77);
    expect_v(S_OUT, 8'h11, "coin_old");
    step();
    expect_v(S_PEND, 8'h01, "coin_pend");
    expect_v(S_NMI, 8'h01, "coin_nmi");
    acc(K_RD, 16'h0000, 8'h00, 1'b0, 8'h00);
    expect_v(S_OUT, 8'h77, "coin_new");
    step();
    expect_v(S_PEND, 8'h00, "coin_clear");

    // NMI disable coincident with CMD_WR
    acc(K_WR, 16'h0008, 8'h00, 1'b0, 8'h00); step();
    acc(K_WR, 16'h0018, 8'h00, 1'b1, 8'h55); step();
    expect_v(S_NMI, 8'h01, "dis_coin_nmi");
    expect_v(S_PEND, 8'h01, "dis_coin_pend");
    acc(K_NONE, 16'h0000, 8'h00, 1'b1, 8'h56); step();
    expect_v(S_NMI, 8'h01, "dis_after_nmi");
    acc(K_RD, 16'h0000, 8'h00, 1'b0, 8'h00);
    expect_v(S_OUT, 8'h56, "dis_rd_out");
    step();

    // back-to-back commands, then NMI clear by IOWR 0x00
    acc(K_WR, 16'h0008, 8'h00, 1'b0, 8'h00); step();
    acc(K_NONE, 16'h0000, 8'h00, 1'b1, 8'h01); step();
    expect_v(S_NMI, 8'h00, "b2b1_nmi");
    acc(K_NONE, 16'h0000, 8'h00, 1'b1, 8'h02); step();
    expect_v(S_PEND, 8'h01, "b2b2_pend");
    expect_v(S_NMI, 8'h00, "b2b2_nmi");
    acc(K_WR, 16'h0000, 8'h00, 1'b0, 8'h00); step();
    expect_v(S_NMI, 8'h01, "wr00_nmi");
    expect_v(S_PEND, 8'h01, "wr00_pend");
    acc(K_RD, 16'h0000, 8'h00, 1'b0, 8'h00);
    expect_v(S_OUT, 8'h02, "b2b_rd_out");
    step();
    expect_v(S_PEND, 8'h00, "b2b_rd_pend");

    // coincident read and CMD_WR with nmi_en=1
    acc(K_NONE, 16'h0000, 8'h00, 1'b1, 8'h21); step();
    acc(K_RD, 16'h0000, 8'h00, 1'b1, 8'h22);
    expect_v(S_OUT, 8'h21, "coin_en_old");
    step();
    expect_v(S_PEND, 8'h01, "coin_en_pend");
    expect_v(S_NMI, 8'h00, "coin_en_nmi");

    // INTACK, memory cycle, unmapped port
    acc(K_ACK, 16'h0000, 8'h00, 1'b0, 8'h00);
    expect_v(S_OUT, 8'hFF, "ack_out");
    expect_v(S_OE, 8'h01, "ack_oe");
    #1;
    n_chk++;
    if (SDD_OUT !== 8'hFF || SDD_OE !== 1'b1) begin
      n_fail++;
      $display("FAIL direct_ack: got %02h oe %b", SDD_OUT, SDD_OE);
    end
    acc(K_MEM, 16'h0000, 8'h00, 1'b0, 8'h00);
    expect_v(S_OE, 8'h00, "mem_oe");
    acc(K_RD, 16'h0005, 8'h00, 1'b0, 8'h00);
    expect_v(S_OE, 8'h00, "unmapped_oe");
    step();

    // reset pulsed mid IORD 0x00 with a pending command
    acc(K_RD, 16'h0000, 8'h00, 1'b0, 8'h00);
    #1 nRESET = 1'b0;
    expect_v(S_PEND, 8'h00, "midrst_pend");
    expect_v(S_NMI, 8'h01, "midrst_nmi");
    expect_v(S_OUT, 8'h00, "midrst_out");
    expect_v(S_OE, 8'h01, "midrst_oe");
    expect_v(S_REPLY, 8'h00, "midrst_reply");
    expect_v(S_B1, 8'h0E, "midrst_b1");
    expect_v(S_B3, 8'h02, "midrst_b3");
    #1;
    n_chk++;
    if (CMD_PENDING !== 1'b0 || nNMI !== 1'b1) begin
      n_fail++;
      $display("FAIL direct_midrst: pend %b nmi %b", CMD_PENDING, nNMI);
    end
    @(posedge CLK_4M); #1 nRESET = 1'b1;
    @(posedge CLK_4M); #1;
    @(posedge CLK_4M); #1;
    step();
    expect_v(S_PEND, 8'h00, "postrst_pend");
    expect_v(S_NMI, 8'h01, "postrst_nmi");

    // bank read held across reset release must not fire
    acc(K_RD, 16'hAB09, 8'h00, 1'b0, 8'h00);
    #1 nRESET = 1'b0;
    @(posedge CLK_4M); #1 nRESET = 1'b1;
    @(posedge CLK_4M); #1;
    @(posedge CLK_4M); #1;
    step();
    expect_v(S_B1, 8'h0E, "held_bank_nofire");
    // a fresh access after release does fire
    acc(K_RD, 16'hAB09, 8'h00, 1'b0, 8'h00); step();
    expect_v(S_B1, 8'hAB, "fresh_bank_fire");

    repeat (3) step();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge CLK_4M);
    while (sb.size() > 0) begin
      chk_t c;
      c = sb.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s: never compared, expected %02h", c.name, c.exp);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/z80_io_resp.md
Z80_IO_RESP -- requirements
Module: z80_io_resp

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named CLK_4M and nRESET.
REQ-002 Port CLK_4M  in  1  Z80 bus clock; all state updates on its rising edge.
REQ-003 Port nRESET  in  1  asynchronous active-low reset.
REQ-004 Port SDA  in  16  Z80 address bus; I/O port select is SDA[4:0], bank value is SDA[15:8].
REQ-005 Port SDD_IN  in  8  Z80 write data, valid while nWR low.
REQ-006 Port SDD_OUT  out  8  read data toward the Z80.
REQ-007 Port SDD_OE  out  1  high when this block drives SDD_OUT onto the bus.
REQ-008 Ports nIORQ, nMREQ, nRD, nWR  in  1 each  Z80 strobes, registered on CLK_4M by the CPU; each access strobe is low for exactly one clock.
REQ-009 Port CMD_DATA  in  8  sound command from the 68k side, synchronous to CLK_4M.
REQ-010 Port CMD_WR  in  1  one-clock strobe; CMD_DATA is valid on that clock.
REQ-011 Port REPLY  out  8  reply byte toward the 68k side.
REQ-012 Port CMD_PENDING  out  1  high from command arrival until the Z80 reads it.
REQ-013 Port nNMI  out  1  NMI request to the Z80, active low.
REQ-014 Ports BANK0..BANK3  out  8 each  ROM window bank registers.

Function
REQ-015 I/O read cycle (IORD) SHALL be nIORQ=0, nRD=0, nMREQ=1; I/O write cycle (IOWR) SHALL be nIORQ=0, nWR=0, nMREQ=1; interrupt acknowledge (INTACK) SHALL be nIORQ=0, nRD=1, nWR=1, nMREQ=1.
REQ-016 Each strobe SHALL be sampled each rising edge; side effects SHALL occur once per access, on the first edge at which the access condition is seen true (previous sample false).
REQ-017 SDD_OUT and SDD_OE SHALL be combinational from registered state and the current strobes/SDA, so read data is valid throughout the clock nRD is low.
REQ-018 IORD SDA[4:0]=0x00: SDD_OUT=command register; side effect: CMD_PENDING<=0, nNMI<=1.
REQ-019 IORD SDA[4:0]=0x08..0x0B: SDD_OUT=0xFF; side effect: BANK(n)<=SDA[15:8], n=SDA[1:0].
REQ-020 IOWR SDA[4:0]=0x08: nmi_en<=1; IOWR 0x18: nmi_en<=0 and nNMI<=1; IOWR 0x0C: REPLY<=SDD_IN; IOWR 0x00: nNMI<=1.
REQ-021 INTACK: SDD_OUT=0xFF, SDD_OE=1, no side effect.
REQ-022 Any other port or memory cycle (nMREQ=0): SDD_OE=0, no side effect; SDD_OE SHALL be 0 whenever nWR=0.
REQ-023 CMD_WR: command register<=CMD_DATA, CMD_PENDING<=1; if nmi_en=1 (value before this edge), nNMI<=0, held low until cleared per REQ-018/020.
REQ-024 CMD_WR on the same edge as a port 0x00 read side effect: read returns old command; new command latched; CMD_PENDING=1; nNMI=0 if nmi_en; CMD_WR wins.
REQ-025 IOWR 0x18 on the same edge as CMD_WR: nmi_en=0, nNMI=1, command still latched.
REQ-026 Back-to-back CMD_WR without read: command overwritten, CMD_PENDING stays 1, nNMI stays low if already low.
REQ-027 No counters wrap; bank registers take SDA[15:8] verbatim, all 8 bits.

Reset
REQ-028 While nRESET=0, regardless of clock: command=0x00, REPLY=0x00, CMD_PENDING=0, nmi_en=0, nNMI=1, BANK0=0x1E, BANK1=0x0E, BANK2=0x06, BANK3=0x02; edge-detect history SHALL read as "no access".
REQ-029 Reset asserted mid-access SHALL abort it with no side effect; an access already low at reset release SHALL NOT fire (edge required).
REQ-030 SDD_OE SHALL remain purely combinational during reset (strobes drive it).

Verification
REQ-031 Reset, IOWR 0x08, CMD_WR CMD_DATA=0x5A -> next edge CMD_PENDING=1, nNMI=0; IORD 0x00 -> SDD_OUT=0x5A, SDD_OE=1, then CMD_PENDING=0, nNMI=1.
REQ-032 nmi_en=0, CMD_WR 0x33 -> CMD_PENDING=1, nNMI stays 1; IORD 0x00 returns 0x33.
REQ-033 IORD with SDA=0x2109, then 0x7F0B -> BANK1=0x21, BANK3=0x7F, BANK0/BANK2 keep 0x1E/0x06.
REQ-034 IOWR 0x0C data 0xA5 -> REPLY=0xA5; IOWR 0x0D -> REPLY unchanged, SDD_OE=0.
REQ-035 CMD_WR 0x77 coincident with IORD 0x00 (old 0x11) -> SDD_OUT=0x11, afterwards command=0x77, CMD_PENDING=1.
REQ-036 INTACK -> SDD_OUT=0xFF, SDD_OE=1; nRESET pulsed mid-IORD 0x00 with pending command -> all REQ-028 values, no read side effect after release.
